// File: rtl/frame_uart_streamer.sv
// Streams one frame from the buffer-frame RAM to the UART transmitter on a host command.
// Define STREAM_CHECKSUM_EN to append an 8-bit sum of the data bytes after the last byte.
module frame_uart_streamer #(
  parameter int unsigned FRAME_LEN = 102,
  parameter int unsigned ADDR_W    = 15,
  parameter logic [7:0]  START_CMD = 8'hEE,
  parameter logic [7:0]  ABORT_CMD = 8'h1B,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic              done
);

  // One extra counter bit so FRAME_LEN == 2**ADDR_W is representable.
  localparam int unsigned      CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR    = 3'd1;
  localparam logic [2:0] RADDR  = 3'd2;
  localparam logic [2:0] RWAIT  = 3'd3;
  localparam logic [2:0] SEND   = 3'd4;
  localparam logic [2:0] TXWAIT = 3'd5;
`ifdef STREAM_CHECKSUM_EN
  localparam logic [2:0] CSUM   = 3'd6;
`endif
  localparam logic [2:0] FIN    = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              issued_q, issued_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef STREAM_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  logic              abort_now;
  logic              quit;

  always_comb begin
    // An abort strobe counts in the very cycle it arrives, so it beats a coincident tx_done.
    abort_now  = abort_q | (rx_valid && (rx_data == ABORT_CMD) && (state_q != IDLE));
    quit       = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    abort_d    = abort_now;
    issued_d   = issued_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ram_addr_d = ram_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef STREAM_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (rx_valid && (rx_data == START_CMD)) begin
          tx_data_d = HEADER;
          cnt_d     = '0;
          busy_d    = 1'b1;
          issued_d  = 1'b0;
          state_d   = HDR;
`ifdef STREAM_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end

      HDR: begin
        if (!issued_q) begin
          if (abort_now) begin
            quit = 1'b1;
          end else begin
            tx_start_d = 1'b1;
            issued_d   = 1'b1;
          end
        end else if (tx_done) begin
          if (abort_now) begin
            quit = 1'b1;
          end else begin
            ram_addr_d = '0;
            state_d    = RADDR;
          end
        end
      end

      // ram_addr was already loaded on the way in; the RAM samples it at the end of this cycle.
      RADDR: begin
        if (abort_now) quit = 1'b1;
        else           state_d = RWAIT;
      end

      RWAIT: begin
        if (abort_now) begin
          quit = 1'b1;
        end else begin
          tx_data_d = ram_q;
`ifdef STREAM_CHECKSUM_EN
          csum_d    = csum_q + ram_q;
`endif
          state_d   = SEND;
        end
      end

      SEND: begin
        if (abort_now) begin
          quit = 1'b1;
        end else begin
          tx_start_d = 1'b1;
          state_d    = TXWAIT;
        end
      end

      TXWAIT: begin
        if (tx_done) begin
          if (abort_now) begin
            quit = 1'b1;
          end else if (cnt_q == LAST) begin
`ifdef STREAM_CHECKSUM_EN
            issued_d = 1'b0;
            state_d  = CSUM;
`else
            state_d  = FIN;
`endif
          end else begin
            cnt_d      = cnt_q + 1'b1;
            ram_addr_d = cnt_d[ADDR_W-1:0];
            state_d    = RADDR;
          end
        end
      end

`ifdef STREAM_CHECKSUM_EN
      CSUM: begin
        if (!issued_q) begin
          if (abort_now) begin
            quit = 1'b1;
          end else begin
            tx_data_d  = csum_q;
            tx_start_d = 1'b1;
            issued_d   = 1'b1;
          end
        end else if (tx_done) begin
          if (abort_now) quit = 1'b1;
          else           state_d = FIN;
        end
      end
`endif

      FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        ram_addr_d = '0;
        abort_d    = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Aborted streams drop straight back to IDLE without done or a checksum byte.
    if (quit) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      abort_d    = 1'b0;
      issued_d   = 1'b0;
      ram_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      issued_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ram_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef STREAM_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      issued_q   <= issued_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ram_addr_q <= ram_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef STREAM_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign ram_addr = ram_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Bench for frame_uart_streamer: idle-command table, cycle-exact timing, abort and reset
// sequences, and randomized frames checked against a frame-level reference model.
module tb_frame_uart_streamer;

  localparam int unsigned FL      = 102;
  localparam int unsigned AW      = 15;
  localparam logic [7:0]  START_B = 8'hEE;
  localparam logic [7:0]  ABORT_B = 8'h1B;
  localparam logic [7:0]  HDR_B   = 8'hA5;
`ifdef STREAM_CHECKSUM_EN
  localparam bit          CSUM_ON = 1'b1;
`else
  localparam bit          CSUM_ON = 1'b0;
`endif

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       inj;
    logic       exp_busy;
    logic [7:0] exp_data;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          mdl_done = 1'b0;
  logic          inj_done = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_q = 8'h00;
  logic          busy;
  logic          done;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];
  int         start_cyc_q[$];
  int         done_cyc_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   cmd_cyc = 0;
  int   done_cnt = 0;
  int   fixed_lat = 0;
  int   tx_left = 0;
  logic [7:0] tx_hold = 8'h00;
  bit   hold_ok = 1'b0;

  assign tx_done = mdl_done | inj_done;

  frame_uart_streamer #(
    .FRAME_LEN(FL),
    .ADDR_W   (AW),
    .START_CMD(START_B),
    .ABORT_CMD(ABORT_B),
    .HEADER   (HDR_B)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .ram_addr(ram_addr),
    .ram_q   (ram_q),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered RAM: data for an address appears one cycle later.
  always @(posedge clk) ram_q <= mem[ram_addr];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transmitter model: logs each byte, holds it for a latency, then strobes tx_done.
  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (!rst_n) hold_ok = 1'b0;
    if (tx_left > 0) begin
      if (hold_ok) check("tx_data_stable", 32'(tx_data), 32'(tx_hold));
      tx_left--;
      if (tx_left == 0) begin
        mdl_done = 1'b1;
        done_cyc_q.push_back(cyc);
      end
    end
    if (tx_start === 1'b1) begin
      check("tx_start_while_sending", 32'(tx_left), 32'd0);
      sent_q.push_back(tx_data);
      start_cyc_q.push_back(cyc);
      tx_hold = tx_data;
      hold_ok = 1'b1;
      tx_left = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    cmd_cyc  = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    sent_q.delete();
    start_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic rand_mem();
    for (int i = 0; i < int'(FL); i++) mem[i] = 8'($urandom);
  endtask

  // Reference frame: header, the first ndata RAM bytes, then their 8-bit sum if enabled.
  task automatic build_exp(input int ndata, input bit with_csum);
    int sum;
    sum = 0;
    exp_q.delete();
    exp_q.push_back(HDR_B);
    for (int i = 0; i < ndata; i++) begin
      exp_q.push_back(mem[i]);
      sum = sum + int'(mem[i]);
    end
    if (with_csum) exp_q.push_back(8'(sum % 256));
  endtask

  task automatic check_stream(input string nm);
    int n;
    check({nm, "_len"}, 32'(sent_q.size()), 32'(exp_q.size()));
    n = (sent_q.size() < exp_q.size()) ? sent_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", nm, i), 32'(sent_q[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sent(input int target, input string nm);
    int k;
    k = 0;
    while (sent_q.size() < target && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check({nm, "_reached"}, 32'(sent_q.size() >= target), 32'd1);
  endtask

  task automatic expect_full(input string nm, input int d0);
    int worst;
    int g;
    build_exp(FL, CSUM_ON);
    check_stream(nm);
    check({nm, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({nm, "_addr0"}, 32'(ram_addr), 32'd0);
    if (start_cyc_q.size() > 0)
      check({nm, "_hdr_lat"}, 32'(start_cyc_q[0] - cmd_cyc), 32'd2);
    worst = 4;
    for (int i = 0; i < int'(FL) && i + 1 < start_cyc_q.size() && i < done_cyc_q.size(); i++) begin
      g = start_cyc_q[i+1] - done_cyc_q[i];
      if (worst == 4 && g != 4) worst = g;
    end
    check({nm, "_gap"}, 32'(worst), 32'd4);
  endtask

  vec_t vecs[7];

  initial begin
    int d0;
    int c0;

    vecs[0] = '{v: 1'b1, d: 8'h00, inj: 1'b0, exp_busy: 1'b0, exp_data: 8'h00};
    vecs[1] = '{v: 1'b1, d: 8'h1B, inj: 1'b0, exp_busy: 1'b0, exp_data: 8'h00};
    vecs[2] = '{v: 1'b1, d: 8'hED, inj: 1'b0, exp_busy: 1'b0, exp_data: 8'h00};
    vecs[3] = '{v: 1'b1, d: 8'hEF, inj: 1'b1, exp_busy: 1'b0, exp_data: 8'h00};
    vecs[4] = '{v: 1'b0, d: 8'hEE, inj: 1'b1, exp_busy: 1'b0, exp_data: 8'h00};
    vecs[5] = '{v: 1'b1, d: 8'hA5, inj: 1'b0, exp_busy: 1'b0, exp_data: 8'h00};
    vecs[6] = '{v: 1'b1, d: 8'hEE, inj: 1'b0, exp_busy: 1'b1, exp_data: HDR_B};

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    for (int i = 0; i < int'(FL); i++) mem[i] = 8'(i + 1);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Idle-state command table; the last row starts the incrementing frame.
    clear_log();
    d0 = done_cnt;
    foreach (vecs[i]) begin
      @(negedge clk);
      rx_valid = vecs[i].v;
      rx_data  = vecs[i].d;
      inj_done = vecs[i].inj;
      cmd_cyc  = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
      inj_done = 1'b0;
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'd0);
    end
    wait_idle("inc");
    expect_full("inc", d0);

    // Cycle-exact timing with a fixed 3-cycle transmitter.
    fixed_lat = 3;
    rand_mem();
    mem[0] = 8'h3C;
    mem[1] = 8'hC3;
    clear_log();
    d0 = done_cnt;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = START_B;
    cmd_cyc  = cyc;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      case (k)
        1: begin
          check("t1_busy", 32'(busy), 32'd1);
          check("t1_hdr", 32'(tx_data), 32'(HDR_B));
          check("t1_no_start", 32'(tx_start), 32'd0);
        end
        2:  check("t2_start", 32'(tx_start), 32'd1);
        3:  check("t3_start_low", 32'(tx_start), 32'd0);
        7:  check("t7_data_hold", 32'(tx_data), 32'(HDR_B));
        8:  check("t8_data", 32'(tx_data), 32'(mem[0]));
        9:  check("t9_start", 32'(tx_start), 32'd1);
        12: check("t12_addr_old", 32'(ram_addr), 32'd0);
        13: check("t13_addr_new", 32'(ram_addr), 32'd1);
        14: check("t14_data_old", 32'(tx_data), 32'(mem[0]));
        15: check("t15_data_new", 32'(tx_data), 32'(mem[1]));
        16: check("t16_start", 32'(tx_start), 32'd1);
        default: ;
      endcase
    end
    wait_idle("timing");
    expect_full("timing", d0);
    fixed_lat = 0;

    // Abort while byte 10 (header is byte 0) is in flight, then restart.
    rand_mem();
    clear_log();
    d0 = done_cnt;
    send_rx(START_B);
    wait_sent(11, "abort10");
    send_rx(ABORT_B);
    wait_idle("abort10");
    repeat (20) @(negedge clk);
    build_exp(10, 1'b0);
    check_stream("abort10");
    check("abort10_done", 32'(done_cnt - d0), 32'd0);
    check("abort10_busy", 32'(busy), 32'd0);
    clear_log();
    send_rx(START_B);
    wait_idle("restart");
    expect_full("restart", d0);

    // Abort in the same cycle as the last data byte's tx_done.
    fixed_lat = 4;
    rand_mem();
    clear_log();
    d0 = done_cnt;
    send_rx(START_B);
    wait_sent(int'(FL) + 1, "abort_last");
    repeat (4) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = ABORT_B;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle("abort_last");
    repeat (10) @(negedge clk);
    build_exp(FL, 1'b0);
    check_stream("abort_last");
    check("abort_last_done", 32'(done_cnt - d0), 32'd0);
    fixed_lat = 0;

    // Second START while busy is ignored.
    rand_mem();
    clear_log();
    d0 = done_cnt;
    send_rx(START_B);
    c0 = cmd_cyc;
    repeat (3) @(negedge clk);
    send_rx(START_B);
    cmd_cyc = c0;
    wait_idle("double");
    repeat (30) @(negedge clk);
    expect_full("double", d0);

    // Asynchronous reset while byte 50 is in flight.
    rand_mem();
    clear_log();
    send_rx(START_B);
    wait_sent(51, "rst50");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst50_tx_start", 32'(tx_start), 32'd0);
    check("rst50_tx_data", 32'(tx_data), 32'd0);
    check("rst50_ram_addr", 32'(ram_addr), 32'd0);
    check("rst50_busy", 32'(busy), 32'd0);
    check("rst50_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst50_stay_idle", 32'(busy), 32'd0);
    check("rst50_no_more_tx", 32'(sent_q.size()), 32'd51);
    rand_mem();
    clear_log();
    d0 = done_cnt;
    send_rx(START_B);
    wait_idle("after_rst");
    expect_full("after_rst", d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
